// File: rtl/plat_scheduler.sv
`timescale 1ns/1ps
// plat_scheduler: frame-synchronous sequencer for the platform slot field.
// Each frame_clk (VGA_VS) rising edge walks every slot once, scrolling it down.
// Slots that fall past the bottom row are recycled to the top with a
// pseudo-random X and a difficulty-based colour. The recycle count is the
// score source. Slot state is exported through a registered read port.
// Optional build macro: PLAT_OVERRUN_EN enables the sticky missed-frame flag.

module plat_scheduler #(
   parameter int NUM_PLATS = 16,
   parameter int SPACING   = 30,
   parameter int Y_MAX     = 479,
   parameter int X_MAX     = 400,
   parameter int DIFF1     = 64,
   parameter int DIFF2     = 256
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic [7:0]  scroll,
   input  logic        init,
   input  logic [3:0]  rd_idx,
   output logic [8:0]  rd_x,
   output logic [8:0]  rd_y,
   output logic [2:0]  rd_color,
   output logic        busy,
   output logic        frame_done,
   output logic [19:0] respawn_cnt,
   output logic [1:0]  difficulty,
   output logic        overrun
);

   localparam int IDX_W = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
   localparam int WRAP  = NUM_PLATS * SPACING;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PLATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_SCAN, S_DONE} state_t;

   // Fold the 9-bit random value into [0, X_MAX); valid because X_MAX >= 256.
   function automatic logic [8:0] spawn_x(input logic [15:0] l);
      logic [8:0] r;
      r = l[8:0];
      if (r >= 9'(X_MAX)) return r - 9'(X_MAX);
      else                return r;
   endfunction

   // Harder levels mix in blue (and at level 2 brown) platforms.
   function automatic logic [1:0] spawn_color(input logic [15:0] l, input logic [1:0] d);
      logic [1:0] c;
      c = 2'd0;
      if (d != 2'd0 && l[1:0] == 2'd0)      c = 2'd1;
      else if (d == 2'd2 && l[1:0] == 2'd1) c = 2'd2;
      return c;
   endfunction

   function automatic logic [19:0] sat_inc(input logic [19:0] c);
      return (c == 20'hFFFFF) ? c : c + 20'd1;
   endfunction

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [7:0]       scroll_q;
   logic             pending;
   logic             boot_q;
   logic             fe_q;
   logic [15:0]      lfsr;
   logic [8:0]       x_mem [NUM_PLATS];
   logic [8:0]       y_mem [NUM_PLATS];
   logic [1:0]       c_mem [NUM_PLATS];

   logic             frame_edge;
   logic [9:0]       ny;
   logic             recycle;
   logic [8:0]       init_y;
   logic [8:0]       spawn_xv;
   logic [1:0]       spawn_cv;
   logic             rd_hit;

   assign frame_edge = frame_clk & ~fe_q;
   assign ny         = {1'b0, y_mem[idx]} + {2'b00, scroll_q};
   assign recycle    = (ny > 10'(Y_MAX));
   assign init_y     = 9'(int'(idx) * SPACING);
   assign spawn_xv   = spawn_x(lfsr);
   assign spawn_cv   = spawn_color(lfsr, difficulty);
   assign rd_hit     = ({28'd0, rd_idx} < 32'(NUM_PLATS));
   assign difficulty = (respawn_cnt >= 20'(DIFF2)) ? 2'd2 :
                       (respawn_cnt >= 20'(DIFF1)) ? 2'd1 : 2'd0;

   // Frame edge detector and free-running Fibonacci LFSR (taps 16,14,13,11)
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fe_q <= 1'b0;
         lfsr <= 16'hACE1;
      end else begin
         fe_q <= frame_clk;
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Control FSM: boot/init layout, per-frame scan, slot storage and recycle count
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= S_IDLE;
         boot_q      <= 1'b1;
         idx         <= '0;
         scroll_q    <= '0;
         pending     <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         respawn_cnt <= '0;
         for (int i = 0; i < NUM_PLATS; i++) begin
            x_mem[i] <= '0;
            y_mem[i] <= '0;
            c_mem[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         // An edge arriving mid-walk is remembered once; init below overrides it.
         if (state != S_IDLE && frame_edge)
            pending <= 1'b1;
         case (state)
            S_IDLE: begin
               if (init || boot_q) begin
                  boot_q  <= 1'b0;
                  pending <= 1'b0;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= S_INIT;
               end else if (frame_edge || pending) begin
                  scroll_q <= scroll;
                  pending  <= 1'b0;
                  idx      <= '0;
                  busy     <= 1'b1;
                  state    <= S_SCAN;
               end
            end
            S_INIT: begin
               respawn_cnt <= '0;
               if (init) begin
                  idx     <= '0;
                  pending <= 1'b0;
               end else begin
                  y_mem[idx] <= init_y;
                  x_mem[idx] <= spawn_xv;
                  c_mem[idx] <= 2'd0;
                  if (idx == LAST) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (init) begin
                  idx     <= '0;
                  pending <= 1'b0;
                  state   <= S_INIT;
               end else begin
                  if (recycle) begin
                     y_mem[idx]  <= 9'(ny - 10'(WRAP));
                     x_mem[idx]  <= spawn_xv;
                     c_mem[idx]  <= spawn_cv;
                     respawn_cnt <= sat_inc(respawn_cnt);
                  end else begin
                     y_mem[idx] <= ny[8:0];
                  end
                  if (idx == LAST) begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (init) begin
                  idx     <= '0;
                  pending <= 1'b0;
                  state   <= S_INIT;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef PLAT_OVERRUN_EN
   // Sticky flag: a frame edge arrived while another was already waiting
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         overrun <= 1'b0;
      else if (state == S_INIT)
         overrun <= 1'b0;
      else if (frame_edge && pending)
         overrun <= 1'b1;
   end
`else
   assign overrun = 1'b0;
`endif

   // Registered read port; a same-cycle write is seen one read later
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_x     <= '0;
         rd_y     <= '0;
         rd_color <= '0;
      end else if (rd_hit) begin
         rd_x     <= x_mem[rd_idx[IDX_W-1:0]];
         rd_y     <= y_mem[rd_idx[IDX_W-1:0]];
         rd_color <= {1'b0, c_mem[rd_idx[IDX_W-1:0]]};
      end else begin
         rd_x     <= '0;
         rd_y     <= '0;
         rd_color <= '0;
      end
   end

endmodule

// File: tb/tb_plat_scheduler.sv
`timescale 1ns/1ps
// Bench for plat_scheduler: randomized frames checked against a slot-level model.

module tb_plat_scheduler;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_clk = 1'b0;
   logic [7:0]  scroll = 8'd0;
   logic        init = 1'b0;
   logic [3:0]  rd_idx = 4'd0;
   logic [8:0]  rd_x, rd_y;
   logic [2:0]  rd_color;
   logic        busy, frame_done, overrun;
   logic [19:0] respawn_cnt;
   logic [1:0]  difficulty;

   int nvec = 0;
   int nfail = 0;

   always #10 Clk = ~Clk;

   plat_scheduler dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .scroll(scroll),
      .init(init), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
      .busy(busy), .frame_done(frame_done), .respawn_cnt(respawn_cnt),
      .difficulty(difficulty), .overrun(overrun)
   );

   // Random source history: hist[n] is the generator value in effect at clock edge n
   logic [15:0] lfsr_m;
   int          cyc = 0;
   logic [15:0] hist [8192];

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   always @(posedge Clk or negedge Reset_n)
      if (!Reset_n) lfsr_m <= 16'hACE1;
      else          lfsr_m <= lstep(lfsr_m);

   always @(posedge Clk) begin
      hist[cyc % 8192] <= lfsr_m;
      cyc <= cyc + 1;
   end

   // Slot-level model
   int my_x [16];
   int my_y [16];
   int my_c [16];
   int cnt_m = 0;
   int dx [16];
   int dy [16];
   int dc [16];

   function automatic int spawn_x_m(input logic [15:0] l);
      int r;
      r = int'(l[8:0]);
      return (r >= 400) ? r - 400 : r;
   endfunction

   function automatic int diff_m(input int c);
      return (c >= 256) ? 2 : (c >= 64) ? 1 : 0;
   endfunction

   function automatic int colour_m(input logic [15:0] l, input int d);
      int lo;
      lo = int'(l[1:0]);
      if (d == 0) return 0;
      if (lo == 0) return 1;
      if (d == 2 && lo == 1) return 2;
      return 0;
   endfunction

   // Layout rebuild whose first slot is written at edge base+1
   task automatic model_init(input int base);
      for (int i = 0; i < 16; i++) begin
         my_y[i] = i * 30;
         my_x[i] = spawn_x_m(hist[(base + 1 + i) % 8192]);
         my_c[i] = 0;
      end
      cnt_m = 0;
   endtask

   // One walk whose frame edge was sampled at clock edge base
   task automatic model_scan(input int base, input int s);
      int ny;
      logic [15:0] l;
      for (int i = 0; i < 16; i++) begin
         l  = hist[(base + 1 + i) % 8192];
         ny = my_y[i] + s;
         if (ny > 479) begin
            my_y[i] = ny - 480;
            my_x[i] = spawn_x_m(l);
            my_c[i] = colour_m(l, diff_m(cnt_m));
            if (cnt_m < 20'hFFFFF) cnt_m = cnt_m + 1;
         end else begin
            my_y[i] = ny;
         end
      end
   endtask

   // Reads every slot through the port; called and returns on a falling edge
   task automatic read_slots();
      rd_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         @(negedge Clk);
         dx[i] = int'(rd_x);
         dy[i] = int'(rd_y);
         dc[i] = int'(rd_color);
         rd_idx = 4'(i + 1);
      end
   endtask

   // Raises one frame edge, waits (bounded) for frame_done, updates the model
   task automatic do_frame(input int s, output int done_k);
      int c0;
      done_k = -1;
      c0 = cyc;
      frame_clk = 1'b1;
      scroll = 8'(s);
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (k == 1) frame_clk = 1'b0;
         if (done_k > 0) break;
         if (frame_done === 1'b1) done_k = k;
      end
      model_scan(c0, s);
   endtask

   task automatic test_reset();
      int c0, nb;
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      nvec++;
      if ({busy, frame_done, overrun, difficulty, respawn_cnt, rd_x, rd_y, rd_color} !== 46'd0) begin
         nfail++;
         $display("FAIL reset_outputs: got busy=%b done=%b ovr=%b diff=%0d cnt=%0d x=%0d y=%0d c=%0d want all 0",
                  busy, frame_done, overrun, difficulty, respawn_cnt, rd_x, rd_y, rd_color);
      end
      c0 = cyc;
      Reset_n = 1'b1;
      nb = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (busy === 1'b1) nb++;
         else if (nb > 0) break;
      end
      nvec++;
      if (nb != 16) begin
         nfail++;
         $display("FAIL reset_init_busy: got %0d busy cycles want 16", nb);
      end
      model_init(c0);
      rd_idx = 4'd5;
      @(negedge Clk);
      nvec++;
      if (rd_y !== 9'd150 || int'(rd_x) != my_x[5] || rd_x >= 9'd400) begin
         nfail++;
         $display("FAIL reset_slot5: got x=%0d y=%0d want x=%0d y=150", rd_x, rd_y, my_x[5]);
      end
      read_slots();
      for (int i = 0; i < 16; i++) begin
         nvec++;
         if (dx[i] != my_x[i] || dy[i] != my_y[i] || dc[i] != my_c[i]) begin
            nfail++;
            $display("FAIL reset_layout[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     i, dx[i], dy[i], dc[i], my_x[i], my_y[i], my_c[i]);
         end
      end
      nvec++;
      if (respawn_cnt !== 20'd0 || difficulty !== 2'd0) begin
         nfail++;
         $display("FAIL reset_counters: got cnt=%0d diff=%0d want 0 0", respawn_cnt, difficulty);
      end
   endtask

   task automatic test_scan_zero();
      int dk;
      do_frame(0, dk);
      nvec++;
      if (dk != 17) begin
         nfail++;
         $display("FAIL zero_latency: got frame_done at +%0d want +17", dk);
      end
      nvec++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL zero_pulse_end: got done=%b busy=%b want 0 0", frame_done, busy);
      end
      read_slots();
      for (int i = 0; i < 16; i++) begin
         nvec++;
         if (dx[i] != my_x[i] || dy[i] != i * 30 || dc[i] != 0) begin
            nfail++;
            $display("FAIL zero_layout[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=0",
                     i, dx[i], dy[i], dc[i], my_x[i], i * 30);
         end
      end
      nvec++;
      if (respawn_cnt !== 20'd0) begin
         nfail++;
         $display("FAIL zero_count: got %0d want 0", respawn_cnt);
      end
   endtask

   task automatic test_boundary();
      int dk;
      int sc [3];
      int ey14 [3];
      int ey15 [3];
      int ecnt [3];
      sc = '{30, 29, 1};
      ey14 = '{450, 479, 0};
      ey15 = '{0, 29, 30};
      ecnt = '{1, 1, 2};
      for (int f = 0; f < 3; f++) begin
         do_frame(sc[f], dk);
         nvec++;
         if (dk != 17) begin
            nfail++;
            $display("FAIL bnd_latency[%0d]: got +%0d want +17", f, dk);
         end
         read_slots();
         nvec++;
         if (dy[14] != ey14[f] || dy[15] != ey15[f]) begin
            nfail++;
            $display("FAIL bnd_y[%0d]: got y14=%0d y15=%0d want %0d %0d", f, dy[14], dy[15], ey14[f], ey15[f]);
         end
         nvec++;
         if (int'(respawn_cnt) != ecnt[f]) begin
            nfail++;
            $display("FAIL bnd_count[%0d]: got %0d want %0d", f, respawn_cnt, ecnt[f]);
         end
         for (int i = 0; i < 16; i++) begin
            nvec++;
            if (dx[i] != my_x[i] || dy[i] != my_y[i] || dc[i] != my_c[i]) begin
               nfail++;
               $display("FAIL bnd_slot[%0d][%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                        f, i, dx[i], dy[i], dc[i], my_x[i], my_y[i], my_c[i]);
            end
         end
      end
   endtask

   task automatic test_difficulty();
      int dk, s, fr;
      bit seen2;
      seen2 = 1'b0;
      fr = 0;
      while (cnt_m < 300 && fr < 200) begin
         s = int'($urandom_range(0, 255));
         do_frame(s, dk);
         fr++;
         nvec++;
         if (dk != 17) begin
            nfail++;
            $display("FAIL diff_latency[%0d]: got +%0d want +17", fr, dk);
         end
         nvec++;
         if (int'(respawn_cnt) != cnt_m || int'(difficulty) != diff_m(cnt_m)) begin
            nfail++;
            $display("FAIL diff_count[%0d]: got cnt=%0d diff=%0d want cnt=%0d diff=%0d",
                     fr, respawn_cnt, difficulty, cnt_m, diff_m(cnt_m));
         end
         read_slots();
         for (int i = 0; i < 16; i++) begin
            if (dc[i] == 2) seen2 = 1'b1;
            nvec++;
            if (dx[i] != my_x[i] || dy[i] != my_y[i] || dc[i] != my_c[i]) begin
               nfail++;
               $display("FAIL diff_slot[%0d][%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                        fr, i, dx[i], dy[i], dc[i], my_x[i], my_y[i], my_c[i]);
            end
         end
      end
      nvec++;
      if (difficulty !== 2'd2 || seen2 != 1'b1) begin
         nfail++;
         $display("FAIL diff_level2: got diff=%0d brown_seen=%0d want 2 1", difficulty, seen2);
      end
   endtask

   task automatic test_back_to_back();
      int c0, s1, s2, d1, d2, nd;
      logic exp_ovr;
`ifdef PLAT_OVERRUN_EN
      exp_ovr = 1'b1;
`else
      exp_ovr = 1'b0;
`endif
      s1 = int'($urandom_range(0, 255));
      s2 = int'($urandom_range(0, 255));
      d1 = -1;
      d2 = -1;
      nd = 0;
      c0 = cyc;
      frame_clk = 1'b1;
      scroll = 8'(s1);
      for (int k = 1; k <= 60; k++) begin
         @(negedge Clk);
         if (frame_done === 1'b1) begin
            nd++;
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k == 18) begin
            nvec++;
            if (busy !== 1'b0) begin
               nfail++;
               $display("FAIL b2b_gap_busy: got %b want 0", busy);
            end
         end
         case (k)
            1, 6, 11: frame_clk = 1'b0;
            5:        begin frame_clk = 1'b1; scroll = 8'(s2 + 77); end
            10:       frame_clk = 1'b1;
            18:       scroll = 8'(s2);
            default:  ;
         endcase
      end
      nvec++;
      if (d1 != 17 || d2 != 35 || nd != 2) begin
         nfail++;
         $display("FAIL b2b_done: got first=+%0d second=+%0d pulses=%0d want +17 +35 2", d1, d2, nd);
      end
      nvec++;
      if (overrun !== exp_ovr) begin
         nfail++;
         $display("FAIL b2b_overrun: got %b want %b", overrun, exp_ovr);
      end
      model_scan(c0, s1);
      model_scan(c0 + 18, s2);
      read_slots();
      for (int i = 0; i < 16; i++) begin
         nvec++;
         if (dx[i] != my_x[i] || dy[i] != my_y[i] || dc[i] != my_c[i]) begin
            nfail++;
            $display("FAIL b2b_slot[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     i, dx[i], dy[i], dc[i], my_x[i], my_y[i], my_c[i]);
         end
      end
      nvec++;
      if (int'(respawn_cnt) != cnt_m) begin
         nfail++;
         $display("FAIL b2b_count: got %0d want %0d", respawn_cnt, cnt_m);
      end
   endtask

   task automatic test_init_abort();
      int c0, nb, nd;
      // init at scan slot 7
      c0 = cyc;
      frame_clk = 1'b1;
      scroll = 8'($urandom_range(0, 255));
      nb = 0;
      nd = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (busy === 1'b1) nb++;
         if (frame_done === 1'b1) nd++;
         if (k == 1) frame_clk = 1'b0;
         if (k == 8) init = 1'b1;
         if (k == 9) init = 1'b0;
      end
      nvec++;
      if (nb != 24 || nd != 0) begin
         nfail++;
         $display("FAIL abort_busy: got busy=%0d done=%0d want 24 0", nb, nd);
      end
      nvec++;
      if (respawn_cnt !== 20'd0 || difficulty !== 2'd0 || overrun !== 1'b0) begin
         nfail++;
         $display("FAIL abort_clear: got cnt=%0d diff=%0d ovr=%b want 0 0 0", respawn_cnt, difficulty, overrun);
      end
      model_init(c0 + 8);
      read_slots();
      for (int i = 0; i < 16; i++) begin
         nvec++;
         if (dx[i] != my_x[i] || dy[i] != i * 30 || dc[i] != 0) begin
            nfail++;
            $display("FAIL abort_layout[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=0",
                     i, dx[i], dy[i], dc[i], my_x[i], i * 30);
         end
      end
      // init together with an edge in IDLE: only the rebuild happens
      c0 = cyc;
      init = 1'b1;
      frame_clk = 1'b1;
      scroll = 8'($urandom_range(1, 255));
      nb = 0;
      nd = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (busy === 1'b1) nb++;
         if (frame_done === 1'b1) nd++;
         if (k == 1) begin init = 1'b0; frame_clk = 1'b0; end
      end
      nvec++;
      if (nb != 16 || nd != 0) begin
         nfail++;
         $display("FAIL init_edge: got busy=%0d done=%0d want 16 0", nb, nd);
      end
      model_init(c0);
      read_slots();
      for (int i = 0; i < 16; i++) begin
         nvec++;
         if (dx[i] != my_x[i] || dy[i] != my_y[i] || dc[i] != 0) begin
            nfail++;
            $display("FAIL init_edge_layout[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=0",
                     i, dx[i], dy[i], dc[i], my_x[i], my_y[i]);
         end
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached (vectors=%0d)", nvec);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge Clk);
      test_reset();
      test_scan_zero();
      test_boundary();
      test_difficulty();
      test_back_to_back();
      test_init_abort();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
